// File: rtl/dmem_lsu_if.sv
// Request, response and word-memory signals between the core, the load/store unit and dmem.
// master = core plus memory side, slave = load/store unit.
interface dmem_lsu_if #(
   parameter int W = 32
);
   logic         req_valid;
   logic         req_we;
   logic [1:0]   req_size;
   logic         req_unsigned;
   logic [W-1:0] req_addr;
   logic [W-1:0] req_wdata;
   logic [W-1:0] load_data;
   logic         stall;
   logic         misaligned;
   logic         read_en;
   logic [W-1:0] read_addr;
   logic [W-1:0] read_data;
   logic         write_en;
   logic [W-1:0] write_addr;
   logic [W-1:0] write_data;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, read_data,
      input  load_data, stall, misaligned, read_en, read_addr, write_en, write_addr, write_data
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, read_data,
      output load_data, stall, misaligned, read_en, read_addr, write_en, write_addr, write_data
   );
endinterface

// File: rtl/dmem_lsu.sv
// Converts byte/half/word loads and stores into aligned word accesses to dmem.
// Loads and word stores take zero cycles; sub-word stores read, merge, then write.
module dmem_lsu #(
   parameter int W          = 32,
   parameter int BIG_ENDIAN = 0
) (
   input logic      clk,
   input logic      rst,
   dmem_lsu_if.slave bus
);
   localparam int NB = W / 8;

   typedef enum logic {IDLE, MERGE} state_t;

   state_t       state;
   logic [W-1:0] merge_word;
   logic [W-1:0] merge_addr;

   logic [W-1:0] aligned_addr;
   logic         bad_req, idle_req, is_load, is_wstore, is_sstore, in_merge;
   logic [7:0]   rd_byte;
   logic [15:0]  rd_half;
   logic         ext_bit;
   logic [W-1:0] ext_data, merged;
   int           blane, hlane;

   assign aligned_addr = {bus.req_addr[W-1:2], 2'b00};
   assign bad_req      = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                         (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                         (bus.req_size == 2'b11);

   // Outputs are qualified by rst so they drop the moment reset asserts, not at the next edge.
   assign idle_req  = rst && state == IDLE && bus.req_valid;
   assign is_load   = idle_req && !bad_req && !bus.req_we;
   assign is_wstore = idle_req && !bad_req && bus.req_we && bus.req_size == 2'b10;
   assign is_sstore = idle_req && !bad_req && bus.req_we && bus.req_size != 2'b10;
   assign in_merge  = rst && state == MERGE;

   always_comb begin
      blane = (BIG_ENDIAN != 0) ? NB - 1 - int'(bus.req_addr[1:0]) : int'(bus.req_addr[1:0]);
      hlane = (BIG_ENDIAN != 0) ? NB / 2 - 1 - int'(bus.req_addr[1]) : int'(bus.req_addr[1]);
      rd_byte = bus.read_data[8*blane +: 8];
      rd_half = bus.read_data[16*hlane +: 16];
      ext_bit = !bus.req_unsigned && ((bus.req_size == 2'b00) ? rd_byte[7] : rd_half[15]);
      case (bus.req_size)
         2'b00:   ext_data = {{(W-8){ext_bit}}, rd_byte};
         2'b01:   ext_data = {{(W-16){ext_bit}}, rd_half};
         default: ext_data = bus.read_data;
      endcase
      merged = bus.read_data;
      if (bus.req_size == 2'b00)
         merged[8*blane +: 8] = bus.req_wdata[7:0];
      else
         merged[16*hlane +: 16] = bus.req_wdata[15:0];
   end

   assign bus.read_en    = is_load || is_sstore;
   assign bus.read_addr  = aligned_addr;
   assign bus.write_en   = is_wstore || in_merge;
   assign bus.write_addr = in_merge ? merge_addr : aligned_addr;
   assign bus.write_data = in_merge ? merge_word : bus.req_wdata;
   assign bus.stall      = is_sstore;
   assign bus.misaligned = idle_req && bad_req;
   assign bus.load_data  = is_load ? ext_data : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         merge_word <= '0;
         merge_addr <= '0;
      end else begin
         case (state)
            IDLE: if (is_sstore) begin
               merge_word <= merged;
               merge_addr <= aligned_addr;
               state      <= MERGE;
            end
            MERGE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit sitting directly upstream of the word-only data memory.
- Takes byte/halfword/word load and store requests from the execute stage and converts them into aligned word accesses.
- Sign- or zero-extends load results; sub-word stores become a two-cycle read-modify-write that stalls the core for one cycle.
- Flags misaligned or illegal requests instead of touching memory.

Parameters:
- W, 32, data/address width.
- BIG_ENDIAN, 0, byte-lane order: 0 = little-endian (byte at offset 0 in bits [7:0]); 1 = big-endian.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- req_valid  in  1  memory request present this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  W  byte address.
- req_wdata  in  W  store data, right-justified.
- load_data  out  W  extended load result, valid in the request cycle.
- stall  out  1  core must hold PC and request inputs this cycle.
- misaligned  out  1  request rejected (misaligned or size 11); no memory access.
- read_en  out  1  to dmem.
- read_addr  out  W  to dmem, bits [1:0] forced to 00.
- read_data  in  W  from dmem, combinational.
- write_en  out  1  to dmem.
- write_addr  out  W  to dmem, bits [1:0] forced to 00.
- write_data  out  W  to dmem.

Behaviour:
- States: IDLE, MERGE. Held state: state, merge_word (W), merge_addr (W).
- Reset (rst=0, async): state=IDLE, merge_word=0, merge_addr=0. All outputs forced to 0: stall, misaligned, read_en, write_en, load_data.
- Reset mid-MERGE abandons the store; no write is issued.
- Alignment check, in IDLE with req_valid:
  - misaligned=1 if size=01 and addr[0]=1, or size=10 and addr[1:0]≠00, or size=11.
  - When misaligned: read_en=write_en=0, stall=0, load_data=0, state unchanged.
- Load, IDLE:
  - read_en=1, read_addr={addr[W-1:2],00}.
  - Select the lane by addr[1:0] and BIG_ENDIAN; extend per req_unsigned.
  - Zero latency, stall=0.
- Word store, IDLE:
  - write_en=1, write_addr aligned, write_data=req_wdata.
  - Single cycle, stall=0.
- Sub-word store, IDLE:
  - read_en=1 and stall=1.
  - At the clock edge: merge_word = read_data with the target byte/half lane replaced by req_wdata[7:0] or [15:0]; merge_addr = aligned addr; state→MERGE.
- MERGE:
  - write_en=1, write_addr=merge_addr, write_data=merge_word, stall=0, read_en=0.
  - Request inputs are ignored (core still presents the same store); next state IDLE.
- req_valid=0 in IDLE: all strobes 0, stall=0, load_data=0.
- Memory-side strobes are never both asserted in the same cycle.
- Exactly one write per accepted store, none for rejected requests.
- Address wrap: no special case; top address bits pass through unchanged.

Test Plan:
- mem[0x10]=0x8899AABB, LE. Load byte addr 0x13 signed → load_data=0xFFFFFF88. Same with unsigned → 0x00000088. Both with stall=0.
- Load half addr 0x12 signed, same word → 0xFFFF8899. Load half addr 0x11 → misaligned=1, read_en=0, load_data=0.
- Store byte 0x5A to addr 0x11 over 0x8899AABB:
  - cycle 0: stall=1, read_en=1.
  - cycle 1: write_en=1, write_addr=0x10, write_data=0x88995ABB, stall=0.
  - Following load word 0x10 returns 0x88995ABB.
- Store word 0xDEADBEEF to addr 0x20 → write_en=1 in the same cycle, stall=0, then read back 0xDEADBEEF. Store word to 0x22 → misaligned=1, no write.
- Assert rst=0 asynchronously during the MERGE cycle of a byte store → stall and write_en drop to 0 immediately, memory unchanged. After release, state IDLE.
- BIG_ENDIAN=1, mem[0x10]=0x8899AABB: load byte addr 0x10 unsigned → 0x88. Store half 0x1234 to 0x12 → written word 0x88991234.
